// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared game-state encoding and default gameplay constants.
//  Revision : 1.0  initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        CRASH     = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam int FUEL_MAX   = 100;
    localparam int LIVES_INIT = 3;

    localparam int NUM_EVENTS = 4;
    localparam int EV_CAR     = 0;
    localparam int EV_FUEL    = 1;
    localparam int EV_SPECIAL = 2;
    localparam int EV_TRUCK   = 3;

endpackage : game_pkg
`default_nettype wire

// File: rtl/frame_event_latch.sv
`default_nettype none
// ============================================================================
//  Module   : frame_event_latch
//  Purpose  : Sticky per-frame capture of a pixel-rate strobe; the frame
//             boundary hands the held value out and restarts capture.
//  Revision : 1.0  initial release
// ============================================================================
module frame_event_latch (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic start_of_frame,
    input  logic hit,
    output logic ev
);

    logic set_q;
    logic set_d;

    // A hit coinciding with the frame boundary belongs to the next frame.
    always_comb begin
        set_d = set_q | hit;
        if (flush) begin
            set_d = 1'b0;
        end else if (start_of_frame) begin
            set_d = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            set_q <= 1'b0;
        end else begin
            set_q <= set_d;
        end
    end

    assign ev = set_q;

endmodule : frame_event_latch
`default_nettype wire

// File: rtl/game_state_manager.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_manager
//  Purpose  : Per-frame game state (fuel, lives, score, crash/invulnerability
//             timing, game over) driven by latched collision events.
//  Revision : 1.0  initial release
// ============================================================================
module game_state_manager #(
    parameter int FUEL_MAX        = game_pkg::FUEL_MAX,
    parameter int FUEL_DEC_FRAMES = 30,
    parameter int FUEL_BONUS      = 25,
    parameter int LIVES_INIT      = game_pkg::LIVES_INIT,
    parameter int CRASH_FRAMES    = 60,
    parameter int INVULN_FRAMES   = 90,
    parameter int SPECIAL_SCORE   = 500,
    parameter int SCORE_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               startGame,
    input  logic               collision,
    input  logic               fuel,
    input  logic               special,
    input  logic               truckCollision,
    output logic [1:0]         gameState,
    output logic [6:0]         fuelLevel,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               invulnerable,
    output logic               crashActive,
    output logic               gameOver
);

    import game_pkg::*;

    localparam int FRAME_W = $clog2(FUEL_DEC_FRAMES + 1);
    localparam int CRASH_W = $clog2(CRASH_FRAMES + 1);
    localparam int INV_W   = $clog2(INVULN_FRAMES + 1);

    localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(FUEL_DEC_FRAMES - 1);
    localparam logic [CRASH_W-1:0] CRASH_LOAD  = CRASH_W'(CRASH_FRAMES);
    localparam logic [INV_W-1:0]   INV_LOAD    = INV_W'(INVULN_FRAMES);
    localparam logic [8:0]         FUEL_FULL9  = 9'(FUEL_MAX);
    localparam logic [8:0]         FUEL_BONUS9 = 9'(FUEL_BONUS);
    localparam logic [6:0]         FUEL_FULL   = 7'(FUEL_MAX);
    localparam logic [1:0]         LIVES_LOAD  = 2'(LIVES_INIT);
    localparam logic [SCORE_W:0]   SPECIAL_INC = (SCORE_W+1)'(SPECIAL_SCORE);

    game_state_t        state_q,     state_d;
    logic [6:0]         fuel_q,      fuel_d;
    logic [1:0]         lives_q,     lives_d;
    logic [SCORE_W-1:0] score_q,     score_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CRASH_W-1:0] crash_cnt_q, crash_cnt_d;
    logic [INV_W-1:0]   invuln_q,    invuln_d;

    logic                  flush;
    logic [NUM_EVENTS-1:0] hit_vec;
    logic [NUM_EVENTS-1:0] ev_vec;

    assign hit_vec[EV_CAR]     = collision;
    assign hit_vec[EV_FUEL]    = fuel;
    assign hit_vec[EV_SPECIAL] = special;
    assign hit_vec[EV_TRUCK]   = truckCollision;

    genvar g;
    generate
        for (g = 0; g < NUM_EVENTS; g++) begin : g_event_latch
            frame_event_latch u_latch (
                .clk            (clk),
                .reset          (reset),
                .flush          (flush),
                .start_of_frame (startOfFrame),
                .hit            (hit_vec[g]),
                .ev             (ev_vec[g])
            );
        end
    endgenerate

    // Per-frame datapath candidates, consumed only in PLAYING.
    logic               frame_wrap;
    logic [FRAME_W-1:0] frame_next;
    logic [8:0]         fuel_sum;
    logic [8:0]         fuel_net9;
    logic [6:0]         fuel_net;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [INV_W-1:0]   invuln_next;
    logic               crash_hit;

    always_comb begin
        frame_wrap = (frame_cnt_q == FRAME_LAST);
        frame_next = frame_wrap ? '0 : frame_cnt_q + 1'b1;

        // Bonus and decrement are netted before clamping to a full tank.
        fuel_sum  = {2'b00, fuel_q} + (ev_vec[EV_FUEL] ? FUEL_BONUS9 : 9'd0);
        fuel_net9 = (frame_wrap && (fuel_sum != 9'd0)) ? fuel_sum - 9'd1 : fuel_sum;
        fuel_net  = (fuel_net9 > FUEL_FULL9) ? FUEL_FULL : fuel_net9[6:0];

        score_sum  = {1'b0, score_q} + {{SCORE_W{1'b0}}, 1'b1}
                   + (ev_vec[EV_SPECIAL] ? SPECIAL_INC : '0);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

        if (ev_vec[EV_SPECIAL]) begin
            invuln_next = INV_LOAD;
        end else if (invuln_q != '0) begin
            invuln_next = invuln_q - 1'b1;
        end else begin
            invuln_next = '0;
        end

        crash_hit = ev_vec[EV_TRUCK] | (ev_vec[EV_CAR] & (invuln_q == '0));
    end

    always_comb begin
        state_d     = state_q;
        fuel_d      = fuel_q;
        lives_d     = lives_q;
        score_d     = score_q;
        frame_cnt_d = frame_cnt_q;
        crash_cnt_d = crash_cnt_q;
        invuln_d    = invuln_q;
        flush       = 1'b0;

        case (state_q)
            IDLE, GAME_OVER: begin
                if (startGame) begin
                    state_d     = PLAYING;
                    fuel_d      = FUEL_FULL;
                    lives_d     = LIVES_LOAD;
                    score_d     = '0;
                    frame_cnt_d = '0;
                    crash_cnt_d = '0;
                    invuln_d    = '0;
                    flush       = 1'b1;
                end
            end

            PLAYING: begin
                if (startOfFrame) begin
                    frame_cnt_d = frame_next;
                    fuel_d      = fuel_net;
                    score_d     = score_next;
                    invuln_d    = invuln_next;
                    if (crash_hit) begin
                        lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                        if (lives_q <= 2'd1) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d     = CRASH;
                            crash_cnt_d = CRASH_LOAD;
                        end
                    end
                    // An empty tank ends the game even when a crash also happened.
                    if (fuel_net == 7'd0) begin
                        state_d = GAME_OVER;
                    end
                end
            end

            CRASH: begin
                if (startOfFrame) begin
                    crash_cnt_d = (crash_cnt_q != '0) ? crash_cnt_q - 1'b1 : '0;
                    if (crash_cnt_q <= {{(CRASH_W-1){1'b0}}, 1'b1}) begin
                        state_d  = PLAYING;
                        invuln_d = INV_LOAD;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fuel_q      <= FUEL_FULL;
            lives_q     <= LIVES_LOAD;
            score_q     <= '0;
            frame_cnt_q <= '0;
            crash_cnt_q <= '0;
            invuln_q    <= '0;
        end else begin
            state_q     <= state_d;
            fuel_q      <= fuel_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            frame_cnt_q <= frame_cnt_d;
            crash_cnt_q <= crash_cnt_d;
            invuln_q    <= invuln_d;
        end
    end

    assign gameState    = state_q;
    assign fuelLevel    = fuel_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign invulnerable = (invuln_q != '0);
    assign crashActive  = (state_q == CRASH);
    assign gameOver     = (state_q == GAME_OVER);

endmodule : game_state_manager
`default_nettype wire

// File: tb/tb_game_state_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_state_manager
//  Purpose  : Directed self-checking bench for game_state_manager.
//  Revision : 1.0  initial release
// ============================================================================
module tb_game_state_manager;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        startGame;
    logic        collision;
    logic        fuel;
    logic        special;
    logic        truckCollision;
    logic [1:0]  gameState;
    logic [6:0]  fuelLevel;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        invulnerable;
    logic        crashActive;
    logic        gameOver;

    int errors = 0;
    int checks = 0;

    game_state_manager dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .startGame      (startGame),
        .collision      (collision),
        .fuel           (fuel),
        .special        (special),
        .truckCollision (truckCollision),
        .gameState      (gameState),
        .fuelLevel      (fuelLevel),
        .lives          (lives),
        .score          (score),
        .invulnerable   (invulnerable),
        .crashActive    (crashActive),
        .gameOver       (gameOver)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        repeat (3) cycle();
        startOfFrame = 1'b1;
        cycle();
        startOfFrame = 1'b0;
    endtask

    task automatic pulse_then_frame(input int which);
        case (which)
            0: collision      = 1'b1;
            1: special        = 1'b1;
            default: truckCollision = 1'b1;
        endcase
        cycle();
        collision      = 1'b0;
        special        = 1'b0;
        truckCollision = 1'b0;
        frame();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(gameState), 0);
        check({tag, "_fuel"},  32'(fuelLevel), 100);
        check({tag, "_lives"}, 32'(lives), 3);
        check({tag, "_score"}, 32'(score), 0);
        check({tag, "_inv"},   32'(invulnerable), 0);
        check({tag, "_crash"}, 32'(crashActive), 0);
        check({tag, "_gover"}, 32'(gameOver), 0);
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; startGame = 1'b0;
        collision = 1'b0; fuel = 1'b0; special = 1'b0; truckCollision = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        check_reset_values("rst");

        startGame = 1'b1; cycle(); startGame = 1'b0;
        check("start_state", 32'(gameState), 1);

        repeat (60) frame();
        check("f60_state", 32'(gameState), 1);
        check("f60_score", 32'(score), 60);
        check("f60_fuel",  32'(fuelLevel), 98);
        check("f60_lives", 32'(lives), 3);

        repeat (240) frame();
        check("f300_fuel",  32'(fuelLevel), 90);
        check("f300_score", 32'(score), 300);

        // Pickup strobe held across many cycles of one frame.
        fuel = 1'b1;
        repeat (2000) cycle();
        fuel = 1'b0;
        frame();
        check("fuel_sat",   32'(fuelLevel), 100);
        check("fuel_score", 32'(score), 301);
        frame();
        check("fuel_once",  32'(fuelLevel), 100);
        check("fuel_once_score", 32'(score), 302);

        pulse_then_frame(0);
        check("car_state", 32'(gameState), 2);
        check("car_lives", 32'(lives), 2);
        check("car_crashact", 32'(crashActive), 1);
        check("car_score", 32'(score), 303);
        repeat (59) frame();
        check("crash59_state", 32'(gameState), 2);
        check("crash59_score", 32'(score), 303);
        frame();
        check("crash_exit_state", 32'(gameState), 1);
        check("crash_exit_inv", 32'(invulnerable), 1);
        check("crash_exit_crashact", 32'(crashActive), 0);

        pulse_then_frame(0);
        check("inv_car_state", 32'(gameState), 1);
        check("inv_car_lives", 32'(lives), 2);
        check("inv_car_score", 32'(score), 304);
        repeat (88) frame();
        check("inv_last_frame", 32'(invulnerable), 1);
        frame();
        check("inv_expired", 32'(invulnerable), 0);
        check("inv_score", 32'(score), 393);
        check("inv_fuel",  32'(fuelLevel), 97);

        pulse_then_frame(1);
        check("special_score", 32'(score), 894);
        check("special_inv", 32'(invulnerable), 1);

        // Strobe landing on the frame-boundary cycle counts next frame.
        special = 1'b1; startOfFrame = 1'b1;
        cycle();
        special = 1'b0; startOfFrame = 1'b0;
        check("sof_special_now", 32'(score), 895);
        frame();
        check("sof_special_next", 32'(score), 1396);

        pulse_then_frame(2);
        check("truck_inv_state", 32'(gameState), 2);
        check("truck_inv_lives", 32'(lives), 1);
        check("truck_inv_score", 32'(score), 1397);
        repeat (60) frame();
        check("truck_exit_state", 32'(gameState), 1);

        pulse_then_frame(2);
        check("over_state", 32'(gameState), 3);
        check("over_lives", 32'(lives), 0);
        check("over_flag",  32'(gameOver), 1);
        check("over_score", 32'(score), 1398);
        frame();
        check("over_frozen_score", 32'(score), 1398);
        check("over_frozen_fuel",  32'(fuelLevel), 97);

        startGame = 1'b1; cycle(); startGame = 1'b0;
        check("restart_state", 32'(gameState), 1);
        check("restart_fuel",  32'(fuelLevel), 100);
        check("restart_lives", 32'(lives), 3);
        check("restart_score", 32'(score), 0);
        check("restart_gover", 32'(gameOver), 0);

        pulse_then_frame(0);
        check("pre_rst_state", 32'(gameState), 2);
        repeat (30) frame();
        check("pre_rst_crash", 32'(gameState), 2);
        reset = 1'b1;
        cycle();
        check_reset_values("midrst");
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_game_state_manager
`default_nettype wire
